apb_fetch_master: RTL and testbench

APB requester that turns a simple valid/ready request port (CPU fetch/load path) into APB SETUP/ACCESS transfers toward the ROM slave and a second peripheral slot, and returns read data or an error on a one-cycle response port. Sits directly upstream of the ROM on the APB bus and owns `psel` generation, address decode and a bus-hang timeout. One transfer is outstanding at a time.

---
 rtl/apb_pkg.sv | 34 +++
 rtl/apb_fetch_master_timeout.sv | 29 ++
 rtl/apb_fetch_master.sv | 130 +++++++++++++
 tb/tb_apb_fetch_master.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB requester types and constants.
// Imported by the fetch master and its timeout counter.
package apb_pkg;

  localparam int APB_AW = 16;
  localparam int APB_DW = 16;

  localparam int SLOT_ROM    = 0;
  localparam int SLOT_PERIPH = 1;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_t;

  typedef struct packed {
    logic [APB_AW-1:0] addr;
    logic              write;
    logic [APB_DW-1:0] wdata;
  } apb_req_t;

  function automatic logic [1:0] slot_sel(
    input logic [1:0] hi,
    input logic [1:0] rom_bits
  );
    logic [1:0] s;
    s = '0;
    if (hi == rom_bits) s[SLOT_ROM] = 1'b1;
    else                s[SLOT_PERIPH] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/apb_fetch_master_timeout.sv
// ACCESS-phase wait counter with clear, enable
// and terminal-count compare.
module apb_timeout_ctr
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic pclk,
  input  logic preset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt_q;

  always_ff @(posedge pclk) begin
    if (!preset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign tc = (cnt_q == 8'(TIMEOUT));

endmodule

// File: rtl/apb_fetch_master.sv
// Valid/ready request port to APB requester with
// two-slot decode and a bus-hang timeout.
module apb_fetch_master
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 15,
  parameter logic [1:0]  ROM_SEL_BITS = 2'b00
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [APB_AW-1:0] req_addr,
  input  logic              req_write,
  input  logic [APB_DW-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [APB_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [APB_AW-1:0] paddr,
  output logic              pwrite,
  output logic [APB_DW-1:0] pwdata,
  output logic [1:0]        psel,
  output logic              penable,
  input  logic              pready,
  input  logic [APB_DW-1:0] prdata
);

  apb_state_t        state_q, state_n;
  apb_req_t          req_q, req_n;
  logic [1:0]        psel_q, psel_n;
  logic              pen_q, pen_n;
  logic              rv_q, rv_n;
  logic              rerr_q, rerr_n;
  logic [APB_DW-1:0] rdat_q, rdat_n;
  logic              ctr_clr, ctr_en, ctr_tc;

  apb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_to (
    .pclk  (pclk),
    .preset(preset),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .tc    (ctr_tc)
  );

  always_ff @(posedge pclk) begin
    if (!preset) begin
      state_q <= APB_IDLE;
      req_q   <= '0;
      psel_q  <= '0;
      pen_q   <= 1'b0;
      rv_q    <= 1'b0;
      rerr_q  <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_n;
      req_q   <= req_n;
      psel_q  <= psel_n;
      pen_q   <= pen_n;
      rv_q    <= rv_n;
      rerr_q  <= rerr_n;
      rdat_q  <= rdat_n;
    end
  end

  always_comb begin
    state_n = state_q;
    req_n   = req_q;
    psel_n  = psel_q;
    pen_n   = pen_q;
    rv_n    = 1'b0;
    rerr_n  = rerr_q;
    rdat_n  = rdat_q;
    ctr_clr = 1'b0;
    ctr_en  = 1'b0;
    unique case (state_q)
      APB_IDLE: begin
        if (req_valid) begin
          req_n.addr  = req_addr;
          req_n.write = req_write;
          req_n.wdata = req_wdata;
          psel_n  = slot_sel(req_addr[15:14], ROM_SEL_BITS);
          state_n = APB_SETUP;
        end
      end
      APB_SETUP: begin
        ctr_clr = 1'b1;
        pen_n   = 1'b1;
        state_n = APB_ACCESS;
      end
      APB_ACCESS: begin
        // pready beats the terminal count on the same edge
        if (pready) begin
          rv_n    = 1'b1;
          rerr_n  = 1'b0;
          rdat_n  = req_q.write ? '0 : prdata;
          psel_n  = '0;
          pen_n   = 1'b0;
          state_n = APB_IDLE;
        end else if (ctr_tc) begin
          rv_n    = 1'b1;
          rerr_n  = 1'b1;
          rdat_n  = '0;
          psel_n  = '0;
          pen_n   = 1'b0;
          state_n = APB_IDLE;
        end else begin
          ctr_en = 1'b1;
        end
      end
      default: begin
        psel_n  = '0;
        pen_n   = 1'b0;
        state_n = APB_IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == APB_IDLE);
  assign rsp_valid = rv_q;
  assign rsp_err   = rerr_q;
  assign rsp_rdata = rdat_q;
  assign paddr     = req_q.addr;
  assign pwrite    = req_q.write;
  assign pwdata    = req_q.wdata;
  assign psel      = psel_q;
  assign penable   = pen_q;

endmodule

// File: tb/tb_apb_fetch_master.sv
// Directed plus randomized bench for apb_fetch_master.
// Expected responses come from a transfer-level model.
module tb_apb_fetch_master;

  localparam int TO = 4;

  logic        pclk = 1'b0;
  logic        preset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] paddr;
  logic        pwrite;
  logic [15:0] pwdata;
  logic [1:0]  psel;
  logic        penable;
  logic        pready = 1'b0;
  logic [15:0] prdata = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_q[$];

  apb_fetch_master #(
    .TIMEOUT(TO),
    .ROM_SEL_BITS(2'b00)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .psel(psel), .penable(penable),
    .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (preset && req_valid && req_ready) acc_q.push_back(cyc);
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One transfer; slave raises pready on ACCESS edge waits+1.
  task automatic xfer(input logic [15:0] a, input logic w,
                      input logic [15:0] wd, input int waits,
                      input logic [15:0] rd);
    logic [1:0]  ep;
    logic [15:0] erd;
    logic        eerr;
    int          en;
    int          n;
    bit          done;
    ep   = (a[15:14] == 2'b00) ? 2'b01 : 2'b10;
    eerr = (waits > TO);
    en   = (eerr ? TO : waits) + 1;
    erd  = (eerr || w) ? 16'h0 : rd;
    req_valid = 1'b1; req_addr = a;
    req_write = w; req_wdata = wd; pready = 1'b0;
    check("idle_ready", {31'b0, req_ready}, 1);
    tick();
    req_valid = 1'b0;
    req_addr = 16'($urandom);
    req_wdata = 16'($urandom);
    req_write = 1'($urandom);
    check("setup_psel", {30'b0, psel}, {30'b0, ep});
    check("setup_pen", {31'b0, penable}, 0);
    check("setup_paddr", {16'b0, paddr}, {16'b0, a});
    check("setup_ready", {31'b0, req_ready}, 0);
    tick();
    check("acc_pen", {31'b0, penable}, 1);
    check("acc_psel", {30'b0, psel}, {30'b0, ep});
    done = 0;
    n = 0;
    while (!done && n < 3 * TO + 8) begin
      n++;
      pready = (n == waits + 1);
      prdata = (n == waits + 1) ? rd : 16'($urandom);
      tick();
      if (rsp_valid) done = 1;
      else begin
        check("hold_paddr", {16'b0, paddr}, {16'b0, a});
        check("hold_pwdata", {16'b0, pwdata}, {16'b0, wd});
        check("hold_pwrite", {31'b0, pwrite}, {31'b0, w});
        check("hold_psel", {30'b0, psel}, {30'b0, ep});
        check("hold_pen", {31'b0, penable}, 1);
      end
    end
    pready = 1'b0;
    check("rsp_seen", {31'b0, done}, 1);
    check("latency", n, en);
    check("rsp_err", {31'b0, rsp_err}, {31'b0, eerr});
    check("rsp_rdata", {16'b0, rsp_rdata}, {16'b0, erd});
    check("rsp_psel", {30'b0, psel}, 0);
    check("rsp_pen", {31'b0, penable}, 0);
    check("rsp_ready", {31'b0, req_ready}, 1);
    tick();
    check("rsp_pulse", {31'b0, rsp_valid}, 0);
    check("idle_paddr", {16'b0, paddr}, {16'b0, a});
  endtask

  initial begin
    int base;
    int n;

    // reset with a request pending
    preset = 1'b0;
    req_valid = 1'b1;
    req_addr = 16'h4321;
    repeat (3) begin
      tick();
      check("rst_psel", {30'b0, psel}, 0);
      check("rst_pen", {31'b0, penable}, 0);
      check("rst_rv", {31'b0, rsp_valid}, 0);
    end
    check("rst_paddr", {16'b0, paddr}, 0);
    check("rst_pwdata", {16'b0, pwdata}, 0);
    check("rst_rdata", {16'b0, rsp_rdata}, 0);
    req_valid = 1'b0;
    preset = 1'b1;
    tick();
    check("rel_ready", {31'b0, req_ready}, 1);
    check("rel_psel", {30'b0, psel}, 0);

    // ROM read, zero waits
    xfer(16'h0005, 1'b0, 16'h0000, 0, 16'hBEEF);
    // peripheral write with 3 wait states
    xfer(16'h8002, 1'b1, 16'h1234, 3, 16'hFFFF);
    // timeout abort
    xfer(16'h0100, 1'b0, 16'h0000, 50, 16'hAAAA);
    // pready on the terminal-count edge
    xfer(16'h4100, 1'b0, 16'h0000, TO, 16'h6789);

    // back-to-back reads with req_valid held
    base = acc_q.size();
    pready = 1'b1;
    prdata = 16'h5A5A;
    req_valid = 1'b1;
    req_addr = 16'h0010;
    req_write = 1'b0;
    n = 0;
    while (acc_q.size() < base + 3 && n < 20) begin
      n++;
      tick();
      if (rsp_valid)
        check("b2b_rdata", {16'b0, rsp_rdata}, 32'h5A5A);
    end
    req_valid = 1'b0;
    check("b2b_count", acc_q.size() - base, 3);
    if (acc_q.size() >= base + 3) begin
      check("b2b_gap1", acc_q[base+1] - acc_q[base], 3);
      check("b2b_gap2", acc_q[base+2] - acc_q[base+1], 3);
    end
    tick();
    tick();
    check("b2b_last", {31'b0, rsp_valid}, 1);
    check("b2b_last_d", {16'b0, rsp_rdata}, 32'h5A5A);
    pready = 1'b0;
    tick();

    // reset in the middle of ACCESS
    req_valid = 1'b1;
    req_addr = 16'hC000;
    req_write = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("mid_pen", {31'b0, penable}, 1);
    preset = 1'b0;
    tick();
    check("mid_psel", {30'b0, psel}, 0);
    check("mid_pen0", {31'b0, penable}, 0);
    check("mid_rv", {31'b0, rsp_valid}, 0);
    preset = 1'b1;
    pready = 1'b1;
    repeat (3) begin
      tick();
      check("mid_norsp", {31'b0, rsp_valid}, 0);
      check("mid_idle", {31'b0, req_ready}, 1);
    end
    pready = 1'b0;
    xfer(16'h0042, 1'b0, 16'h0000, 1, 16'h1357);

    // randomized transfers
    for (int i = 0; i < 16; i++) begin
      xfer(16'($urandom), 1'($urandom), 16'($urandom),
           int'($urandom_range(0, 7)), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
